// File: rtl/l2_arb_pkg.sv
// Shared definitions for the two-core L2 port arbiter and the L1 caches that use it:
// owner encoding and the tag/index split of an L2 word address.
package l2_arb_pkg;

    localparam int L2_DATA_W = 32;
    localparam int L2_ADDR_W = 15;

    localparam int TAG_HI   = 14;
    localparam int TAG_LO   = 10;
    localparam int INDEX_HI = 9;
    localparam int INDEX_LO = 4;
    localparam int TAG_W    = TAG_HI - TAG_LO + 1;
    localparam int INDEX_W  = INDEX_HI - INDEX_LO + 1;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_t;

    function automatic owner_t own_of(input logic core);
        return core ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/l2_bus_arbiter.sv
// Round-robin arbiter sharing one L2 port between two write-through L1 caches.
// Registered grant, combinational muxing, snoop forwarding and per-core statistics.
module l2_bus_arbiter
    import l2_arb_pkg::*;
#(
    parameter int n      = L2_DATA_W,
    parameter int ADDR_W = L2_ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_l2_stall,
    input  logic [ADDR_W-1:0]   i_core0_l2_word_address,
    input  logic [n-1:0]        i_core0_l2_write_word,
    input  logic                i_core0_l2_read_request,
    input  logic                i_core0_l2_write_request,
    input  logic [ADDR_W-1:0]   i_core1_l2_word_address,
    input  logic [n-1:0]        i_core1_l2_write_word,
    input  logic                i_core1_l2_read_request,
    input  logic                i_core1_l2_write_request,
    input  logic [n-1:0]        i_l2_read_word,
    output logic [ADDR_W-1:0]   o_l2_word_address,
    output logic [n-1:0]        o_l2_write_word,
    output logic                o_l2_read_request,
    output logic                o_l2_write_request,
    output logic                o_core0_l2_busy,
    output logic [n-1:0]        o_core0_l2_read_word,
    output logic                o_core0_others_read_request,
    output logic                o_core0_others_write_request,
    output logic [TAG_W-1:0]    o_core0_others_block_tag,
    output logic [INDEX_W-1:0]  o_core0_others_block_index,
    output logic                o_core1_l2_busy,
    output logic [n-1:0]        o_core1_l2_read_word,
    output logic                o_core1_others_read_request,
    output logic                o_core1_others_write_request,
    output logic [TAG_W-1:0]    o_core1_others_block_tag,
    output logic [INDEX_W-1:0]  o_core1_others_block_index,
    output logic [31:0]         o_arb_statistics
);

    owner_t              r_owner;
    owner_t              w_owner_next;
    logic                r_rr;
    logic                w_rr_next;
    logic [ADDR_W-1:0]   r_addr_hold;

    logic [ADDR_W-1:0]   w_addr [2];
    logic [n-1:0]        w_wdata [2];
    logic [1:0]          w_rd;
    logic [1:0]          w_wr;
    logic [1:0]          w_req;
    logic [1:0]          w_busy;
    logic [1:0]          w_snoop_rd;
    logic [1:0]          w_snoop_wr;
    logic [TAG_W-1:0]    w_snoop_tag [2];
    logic [INDEX_W-1:0]  w_snoop_index [2];
    logic [CNT_W-1:0]    w_grant_cnt [2];
    logic [CNT_W-1:0]    w_wait_cnt [2];

    logic [ADDR_W-1:0]   w_l2_addr;
    logic [n-1:0]        w_l2_wdata;
    logic                w_l2_rd;
    logic                w_l2_wr;

    assign w_addr[0]  = i_core0_l2_word_address;
    assign w_addr[1]  = i_core1_l2_word_address;
    assign w_wdata[0] = i_core0_l2_write_word;
    assign w_wdata[1] = i_core1_l2_write_word;
    assign w_rd       = {i_core1_l2_read_request,  i_core0_l2_read_request};
    assign w_wr       = {i_core1_l2_write_request, i_core0_l2_write_request};

    // Ownership is kept while the owner's request stays high, so a refill train
    // (or write followed by refill) is never split; hand-off to a waiter has no bubble.
    always_comb begin
        w_owner_next = r_owner;
        w_rr_next    = r_rr;
        if (!i_l2_stall) begin
            case (r_owner)
                FREE: begin
                    if (w_req[0] && w_req[1]) begin
                        w_owner_next = own_of(r_rr);
                        w_rr_next    = ~r_rr;
                    end else if (w_req[0]) begin
                        w_owner_next = OWN0;
                    end else if (w_req[1]) begin
                        w_owner_next = OWN1;
                    end
                end
                OWN0: begin
                    if (!w_req[0]) begin
                        w_owner_next = w_req[1] ? OWN1 : FREE;
                    end
                end
                OWN1: begin
                    if (!w_req[1]) begin
                        w_owner_next = w_req[0] ? OWN0 : FREE;
                    end
                end
                default: w_owner_next = FREE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner     <= FREE;
            r_rr        <= 1'b0;
            r_addr_hold <= '0;
        end else begin
            r_owner     <= w_owner_next;
            r_rr        <= w_rr_next;
            r_addr_hold <= w_l2_addr;
        end
    end

    // With no owner the address keeps its last driven value; everything else goes quiet.
    always_comb begin
        w_l2_addr  = r_addr_hold;
        w_l2_wdata = '0;
        w_l2_rd    = 1'b0;
        w_l2_wr    = 1'b0;
        case (r_owner)
            OWN0: begin
                w_l2_addr  = w_addr[0];
                w_l2_wdata = w_wdata[0];
                w_l2_rd    = w_rd[0];
                w_l2_wr    = w_wr[0];
            end
            OWN1: begin
                w_l2_addr  = w_addr[1];
                w_l2_wdata = w_wdata[1];
                w_l2_rd    = w_rd[1];
                w_l2_wr    = w_wr[1];
            end
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_core
            localparam owner_t OWN_ME    = (gi == 0) ? OWN0 : OWN1;
            localparam owner_t OWN_OTHER = (gi == 0) ? OWN1 : OWN0;
            localparam int     OTHER     = 1 - gi;

            logic             w_grant_evt;
            logic             w_wait_evt;
            logic             w_other_owns;
            logic [CNT_W-1:0] r_grant_cnt;
            logic [CNT_W-1:0] r_wait_cnt;

            assign w_req[gi]    = w_rd[gi] | w_wr[gi];
            assign w_other_owns = (r_owner == OWN_OTHER);
            assign w_busy[gi]   = i_l2_stall | (w_req[gi] & (r_owner != OWN_ME));

            // Only a stall behind the other core's grant counts as waiting; the
            // single set-up cycle out of FREE does not.
            assign w_grant_evt = ~i_l2_stall & (r_owner != OWN_ME) & (w_owner_next == OWN_ME);
            assign w_wait_evt  = ~i_l2_stall & w_req[gi] & w_other_owns;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_grant_cnt <= '0;
                    r_wait_cnt  <= '0;
                end else begin
                    if (w_grant_evt) r_grant_cnt <= r_grant_cnt + 1'b1;
                    if (w_wait_evt)  r_wait_cnt  <= r_wait_cnt + 1'b1;
                end
            end

            assign w_grant_cnt[gi]   = r_grant_cnt;
            assign w_wait_cnt[gi]    = r_wait_cnt;
            assign w_snoop_rd[gi]    = w_other_owns & w_rd[OTHER];
            assign w_snoop_wr[gi]    = w_other_owns & w_wr[OTHER];
            assign w_snoop_tag[gi]   = w_other_owns ? w_addr[OTHER][TAG_HI:TAG_LO] : '0;
            assign w_snoop_index[gi] = w_other_owns ? w_addr[OTHER][INDEX_HI:INDEX_LO] : '0;
        end
    endgenerate

    assign o_l2_word_address  = w_l2_addr;
    assign o_l2_write_word    = w_l2_wdata;
    assign o_l2_read_request  = w_l2_rd;
    assign o_l2_write_request = w_l2_wr;

    assign o_core0_l2_busy              = w_busy[0];
    assign o_core0_l2_read_word         = i_l2_read_word;
    assign o_core0_others_read_request  = w_snoop_rd[0];
    assign o_core0_others_write_request = w_snoop_wr[0];
    assign o_core0_others_block_tag     = w_snoop_tag[0];
    assign o_core0_others_block_index   = w_snoop_index[0];

    assign o_core1_l2_busy              = w_busy[1];
    assign o_core1_l2_read_word         = i_l2_read_word;
    assign o_core1_others_read_request  = w_snoop_rd[1];
    assign o_core1_others_write_request = w_snoop_wr[1];
    assign o_core1_others_block_tag     = w_snoop_tag[1];
    assign o_core1_others_block_index   = w_snoop_index[1];

    assign o_arb_statistics = {w_grant_cnt[0], w_grant_cnt[1], w_wait_cnt[0], w_wait_cnt[1]};

endmodule

// File: tb/tb_l2_bus_arbiter.sv
// Scoreboard bench for l2_bus_arbiter: stimulus queues expected L2-port beats,
// a negedge monitor pops and compares every unstalled beat the arbiter presents.
module tb_l2_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        l2_stall = 1'b0;
    logic [14:0] c0_addr = '0;
    logic [31:0] c0_wdata = '0;
    logic        c0_rd = 1'b0;
    logic        c0_wr = 1'b0;
    logic [14:0] c1_addr = '0;
    logic [31:0] c1_wdata = '0;
    logic        c1_rd = 1'b0;
    logic        c1_wr = 1'b0;
    logic [31:0] l2_rdata = 32'hA5A5_5A5A;

    logic [14:0] l2_addr;
    logic [31:0] l2_wdata;
    logic        l2_rd;
    logic        l2_wr;
    logic        busy0;
    logic [31:0] rword0;
    logic        snp0_rd;
    logic        snp0_wr;
    logic [4:0]  snp0_tag;
    logic [5:0]  snp0_idx;
    logic        busy1;
    logic [31:0] rword1;
    logic        snp1_rd;
    logic        snp1_wr;
    logic [4:0]  snp1_tag;
    logic [5:0]  snp1_idx;
    logic [31:0] stats;

    l2_bus_arbiter dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .i_l2_stall                   (l2_stall),
        .i_core0_l2_word_address      (c0_addr),
        .i_core0_l2_write_word        (c0_wdata),
        .i_core0_l2_read_request      (c0_rd),
        .i_core0_l2_write_request     (c0_wr),
        .i_core1_l2_word_address      (c1_addr),
        .i_core1_l2_write_word        (c1_wdata),
        .i_core1_l2_read_request      (c1_rd),
        .i_core1_l2_write_request     (c1_wr),
        .i_l2_read_word               (l2_rdata),
        .o_l2_word_address            (l2_addr),
        .o_l2_write_word              (l2_wdata),
        .o_l2_read_request            (l2_rd),
        .o_l2_write_request           (l2_wr),
        .o_core0_l2_busy              (busy0),
        .o_core0_l2_read_word         (rword0),
        .o_core0_others_read_request  (snp0_rd),
        .o_core0_others_write_request (snp0_wr),
        .o_core0_others_block_tag     (snp0_tag),
        .o_core0_others_block_index   (snp0_idx),
        .o_core1_l2_busy              (busy1),
        .o_core1_l2_read_word         (rword1),
        .o_core1_others_read_request  (snp1_rd),
        .o_core1_others_write_request (snp1_wr),
        .o_core1_others_block_tag     (snp1_tag),
        .o_core1_others_block_index   (snp1_idx),
        .o_arb_statistics             (stats)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [14:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic push_train(input logic rd, input logic wr, input logic [14:0] a,
                              input logic [31:0] d, input int cnt);
        txn_t t;
        t.rd   = rd;
        t.wr   = wr;
        t.addr = a;
        t.data = d;
        for (int k = 0; k < cnt; k++) exp_q.push_back(t);
    endtask

    task automatic set_req(input int c, input logic rd, input logic wr,
                           input logic [14:0] a, input logic [31:0] d);
        if (c == 0) begin
            c0_rd = rd; c0_wr = wr; c0_addr = a; c0_wdata = d;
        end else begin
            c1_rd = rd; c1_wr = wr; c1_addr = a; c1_wdata = d;
        end
    endtask

    function automatic logic busy_of(input int c);
        return (c == 0) ? busy0 : busy1;
    endfunction

    // Behaves like an L1: holds its request until it has had 17 (read) or 2 (write)
    // cycles without busy, then drops it.
    task automatic l1_access(input int c, input logic is_wr, input logic [14:0] a,
                             input logic [31:0] d);
        int need;
        int got;
        int cyc;
        need = is_wr ? 2 : 17;
        got  = 0;
        cyc  = 0;
        set_req(c, !is_wr, is_wr, a, d);
        while (got < need && cyc < 200) begin
            @(negedge clk);
            if (!busy_of(c)) got++;
            step();
            cyc++;
        end
        check($sformatf("access_done_core%0d", c), got, need);
        set_req(c, 1'b0, 1'b0, a, d);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Monitor: every unstalled L2 beat must match the head of the expected queue.
    initial begin
        txn_t got;
        txn_t e;
        forever begin
            @(negedge clk);
            if (rst_n && !l2_stall && (l2_rd || l2_wr)) begin
                got.rd   = l2_rd;
                got.wr   = l2_wr;
                got.addr = l2_addr;
                got.data = l2_wdata;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL l2_txn: got rd=%0b wr=%0b addr=%h data=%h, expected no beat",
                             got.rd, got.wr, got.addr, got.data);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_errors++;
                        $display("FAIL l2_txn: got rd=%0b wr=%0b addr=%h data=%h, expected rd=%0b wr=%0b addr=%h data=%h",
                                 got.rd, got.wr, got.addr, got.data, e.rd, e.wr, e.addr, e.data);
                    end else begin
                        $display("l2 beat rd=%0b wr=%0b addr=%h data=%h ok", got.rd, got.wr, got.addr, got.data);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        step();
        step();
        check("rst_l2_rd", l2_rd, 0);
        check("rst_stats", stats, 32'h0);
        rst_n = 1'b1;
        step();
        check("idle_l2_addr", l2_addr, 15'h0);
        check("idle_l2_req", {l2_rd, l2_wr}, 2'b00);
        check("idle_busy", {busy0, busy1}, 2'b00);
        check("idle_snoops", {snp0_rd, snp0_wr, snp1_rd, snp1_wr}, 4'h0);
        check("bcast_rword0", rword0, 32'hA5A5_5A5A);
        check("bcast_rword1", rword1, 32'hA5A5_5A5A);

        // 1: lone core0 refill from FREE
        push_train(1'b1, 1'b0, 15'h0A50, 32'hC0DE_0000, 17);
        fork
            l1_access(0, 1'b0, 15'h0A50, 32'hC0DE_0000);
            begin
                #1 check("s1_busy0_t0", busy0, 1);
                step();
                #1 check("s1_busy0_t1", busy0, 0);
                check("s1_l2_rd_t1", l2_rd, 1);
            end
        join
        step();
        c0_addr = 15'h7FFF;
        #1 check("s1_addr_hold", l2_addr, 15'h0A50);
        check("s1_free_rd", l2_rd, 0);
        check("s1_stats", stats, 32'h0100_0000);

        // 2: simultaneous refills after reset, core0 first, core1 with no FREE gap
        do_reset();
        push_train(1'b1, 1'b0, 15'h1111, 32'h0000_1111, 17);
        push_train(1'b1, 1'b0, 15'h2222, 32'h0000_2222, 17);
        fork
            l1_access(0, 1'b0, 15'h1111, 32'h0000_1111);
            l1_access(1, 1'b0, 15'h2222, 32'h0000_2222);
            begin
                #1 check("s2_busy_t0", {busy0, busy1}, 2'b11);
                step();
                #1 check("s2_busy_t1", {busy0, busy1}, 2'b01);
                check("s2_snoop1_rd", snp1_rd, 1);
                check("s2_snoop1_tag", snp1_tag, 5'h04);
                check("s2_snoop1_idx", snp1_idx, 6'h11);
                check("s2_snoop0_none", {snp0_rd, snp0_wr}, 2'b00);
                repeat (17) step();
                #1 check("s2_busy1_t18", busy1, 1);
                step();
                #1 check("s2_busy1_t19", busy1, 0);
            end
        join
        check("s2_stats", stats, 32'h0101_0012);
        step();

        // 3: core1 write-through snooped by core0
        push_train(1'b0, 1'b1, 15'h1234, 32'hDEAD_BEEF, 2);
        fork
            l1_access(1, 1'b1, 15'h1234, 32'hDEAD_BEEF);
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check($sformatf("s3_snoop0_wr_c%0d", k), snp0_wr, (k == 1 || k == 2) ? 1 : 0);
                    if (k == 1 || k == 2) begin
                        check("s3_snoop0_tag", snp0_tag, 5'h04);
                        check("s3_snoop0_idx", snp0_idx, 6'h23);
                    end
                    check("s3_snoop1_none", {snp1_rd, snp1_wr}, 2'b00);
                end
            end
        join
        step();

        // 4: two rounds of simultaneous writes alternate winners
        do_reset();
        push_train(1'b0, 1'b1, 15'h0100, 32'h1111_1111, 2);
        push_train(1'b0, 1'b1, 15'h0200, 32'h2222_2222, 2);
        fork
            l1_access(0, 1'b1, 15'h0100, 32'h1111_1111);
            l1_access(1, 1'b1, 15'h0200, 32'h2222_2222);
        join
        step();
        push_train(1'b0, 1'b1, 15'h0400, 32'h4444_4444, 2);
        push_train(1'b0, 1'b1, 15'h0300, 32'h3333_3333, 2);
        fork
            l1_access(0, 1'b1, 15'h0300, 32'h3333_3333);
            l1_access(1, 1'b1, 15'h0400, 32'h4444_4444);
        join
        check("s4_stats", stats, 32'h0202_0303);
        step();

        // 5: l2_stall in the middle of a refill with core1 queued behind
        do_reset();
        push_train(1'b1, 1'b0, 15'h3C00, 32'h55AA_55AA, 17);
        push_train(1'b0, 1'b1, 15'h0042, 32'h0BAD_F00D, 2);
        fork
            l1_access(0, 1'b0, 15'h3C00, 32'h55AA_55AA);
            begin
                repeat (3) step();
                l1_access(1, 1'b1, 15'h0042, 32'h0BAD_F00D);
            end
            begin
                repeat (6) step();
                l2_stall = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    #1 check($sformatf("s5_busy_stall%0d", k), {busy0, busy1}, 2'b11);
                    check($sformatf("s5_stats_stall%0d", k), stats, 32'h0100_0003);
                    check($sformatf("s5_addr_stall%0d", k), l2_addr, 15'h3C00);
                    step();
                end
                l2_stall = 1'b0;
                #1 check("s5_stats_resume", stats, 32'h0100_0003);
                check("s5_busy0_resume", busy0, 0);
            end
        join
        check("s5_stats_end", stats, 32'h0101_0010);
        step();

        // 6: asynchronous reset while core1 owns the port
        do_reset();
        push_train(1'b1, 1'b0, 15'h7ABC, 32'h7777_0000, 1);
        set_req(1, 1'b1, 1'b0, 15'h7ABC, 32'h7777_0000);
        step();
        step();
        check("s6_stats_pre", stats, 32'h0001_0000);
        check("s6_snoop0_pre", snp0_rd, 1);
        #1 rst_n = 1'b0;
        #1 check("s6_l2_req", {l2_rd, l2_wr}, 2'b00);
        check("s6_snoops", {snp0_rd, snp0_wr, snp1_rd, snp1_wr}, 4'h0);
        check("s6_snoop0_tag", snp0_tag, 5'h00);
        check("s6_stats", stats, 32'h0);
        check("s6_l2_addr", l2_addr, 15'h0);
        l2_rdata = 32'h1357_9BDF;
        #1 check("s6_bcast_rword0", rword0, 32'h1357_9BDF);
        check("s6_bcast_rword1", rword1, 32'h1357_9BDF);
        set_req(1, 1'b0, 1'b0, 15'h7ABC, 32'h7777_0000);
        step();
        rst_n = 1'b1;
        repeat (3) step();

        check("scoreboard_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
